// File: rtl/breakout_round_ctrl.sv
// Breakout game sequencer. It tracks lives, score and level, parks or launches
// the ball, re-serves after a miss, and requests brick-wall reloads.
// Every output is a register that is loaded from the next-state logic.
module breakout_round_ctrl #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int LOST_FRAMES  = 90,
  parameter int POINTS       = 10,
  parameter int SCORE_W      = 16,
  parameter int MAX_LEVEL    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               brick_hit,
  input  logic               ball_lost,
  input  logic               bricks_clear,
  output logic               ball_run,
  output logic               ball_hold,
  output logic               brick_reload,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         level,
  output logic               game_over,
  output logic               win
);

  typedef enum logic [2:0] {
    S_IDLE, S_SERVE, S_PLAY, S_LOST, S_LVL_CLR, S_GAME_OVER, S_WIN
  } state_t;

  // One down-counter is shared by the serve hold and the post-miss pause.
  localparam int CNT_MAX = (SERVE_FRAMES > LOST_FRAMES) ? SERVE_FRAMES : LOST_FRAMES;
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] SERVE_LD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] LOST_LD  = CNT_W'(LOST_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // The score sum is made wide enough that it cannot wrap before the clamp.
  localparam int SUM_W = SCORE_W + 32;
  localparam logic [SUM_W-1:0]   SCORE_CAP  = SUM_W'({SCORE_W{1'b1}});
  localparam logic [SUM_W-1:0]   POINTS_EXT = SUM_W'(POINTS);
  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
  localparam logic [2:0]         LVL_LAST   = 3'(MAX_LEVEL);
  localparam logic [2:0]         ONE3       = 3'd1;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [2:0]         lives_n, level_n;
  logic [SCORE_W-1:0] score_n, score_inc;
  logic [SUM_W-1:0]   score_sum;
  logic               reload_n;
  logic               start_q, armed, start_edge;

  // A start already high as reset releases must not count as a press, so
  // edges are only accepted once one post-reset cycle has seeded start_q.
  assign start_edge = start & ~start_q & armed;

  // Score plus one brick's worth of points, clamped at all-ones.
  always_comb begin
    score_sum = SUM_W'(score) + POINTS_EXT;
    score_inc = (score_sum > SCORE_CAP) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

  // Next-state and next-value decode for the game sequence.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    lives_n  = lives;
    score_n  = score;
    level_n  = level;
    reload_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_edge) begin
          state_n = S_SERVE;
          cnt_n   = SERVE_LD;
        end
      end
      S_SERVE: begin
        // A zero-length serve launches without waiting for a tick.
        if (cnt == CNT_ZERO) begin
          state_n = S_PLAY;
        end else if (frame_tick) begin
          cnt_n = cnt - CNT_ONE;
          if (cnt == CNT_ONE) state_n = S_PLAY;
        end
      end
      S_PLAY: begin
        if (brick_hit) score_n = score_inc;
        // Clearing the wall outranks a miss in the same cycle.
        if (bricks_clear) begin
          state_n = S_LVL_CLR;
        end else if (ball_lost) begin
          lives_n = lives - ONE3;
          if (lives > ONE3) begin
            state_n = S_LOST;
            cnt_n   = LOST_LD;
          end else begin
            state_n = S_GAME_OVER;
          end
        end
      end
      S_LOST: begin
        if (cnt == CNT_ZERO) begin
          state_n = S_SERVE;
          cnt_n   = SERVE_LD;
        end else if (frame_tick) begin
          cnt_n = cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state_n = S_SERVE;
            cnt_n   = SERVE_LD;
          end
        end
      end
      S_LVL_CLR: begin
        if (level == LVL_LAST) begin
          state_n = S_WIN;
        end else begin
          level_n  = level + ONE3;
          reload_n = 1'b1;
          cnt_n    = SERVE_LD;
          state_n  = S_SERVE;
        end
      end
      S_GAME_OVER, S_WIN: begin
        if (start_edge) begin
          lives_n  = LIVES_INIT;
          score_n  = '0;
          level_n  = ONE3;
          reload_n = 1'b1;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, counters and registered outputs; reset discards any pending count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      lives        <= LIVES_INIT;
      score        <= '0;
      level        <= ONE3;
      ball_run     <= 1'b0;
      ball_hold    <= 1'b1;
      brick_reload <= 1'b0;
      game_over    <= 1'b0;
      win          <= 1'b0;
      start_q      <= 1'b0;
      armed        <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      lives        <= lives_n;
      score        <= score_n;
      level        <= level_n;
      ball_run     <= (state_n == S_PLAY);
      ball_hold    <= (state_n != S_PLAY);
      brick_reload <= reload_n;
      game_over    <= (state_n == S_GAME_OVER);
      win          <= (state_n == S_WIN);
      start_q      <= start;
      armed        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_breakout_round_ctrl.sv
// Directed bench for breakout_round_ctrl: a behavioural game model is
// compared with the DUT on every cycle, plus literal checkpoint values.
module tb_breakout_round_ctrl;
  localparam int LIVES = 3, SERVE_FRAMES = 2, LOST_FRAMES = 3;
  localparam int POINTS = 10, SCORE_W = 8, MAX_LEVEL = 4;

  logic clk = 1'b0;
  logic reset = 1'b0, start = 1'b0, frame_tick = 1'b0;
  logic brick_hit = 1'b0, ball_lost = 1'b0, bricks_clear = 1'b0;
  logic ball_run, ball_hold, brick_reload, game_over, win;
  logic [2:0] lives, level;
  logic [SCORE_W-1:0] score;

  int total = 0, bad = 0;

  breakout_round_ctrl #(.LIVES(LIVES), .SERVE_FRAMES(SERVE_FRAMES),
    .LOST_FRAMES(LOST_FRAMES), .POINTS(POINTS), .SCORE_W(SCORE_W),
    .MAX_LEVEL(MAX_LEVEL)) dut (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
    .brick_hit(brick_hit), .ball_lost(ball_lost), .bricks_clear(bricks_clear),
    .ball_run(ball_run), .ball_hold(ball_hold), .brick_reload(brick_reload),
    .lives(lives), .score(score), .level(level), .game_over(game_over), .win(win));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: the ball is "waiting" while frames remain to be counted,
  // "in play" otherwise; phase names describe the game, not the RTL.
  typedef enum int {P_MENU, P_WAIT_SERVE, P_RALLY, P_MISSED, P_CLEARED, P_DEAD, P_CHAMP} phase_t;
  phase_t m_phase;
  int m_wait, m_lives, m_score, m_level, m_since_reset;
  bit m_reload, m_prev_start, m_valid = 0;

  always @(posedge clk) begin
    bit press;
    if (!reset) begin
      m_phase = P_MENU; m_wait = 0; m_lives = LIVES; m_score = 0; m_level = 1;
      m_reload = 0; m_prev_start = 0; m_since_reset = 0; m_valid = 1;
    end else if (m_valid) begin
      press = start && !m_prev_start && (m_since_reset > 0);
      m_prev_start = start;
      m_since_reset++;
      m_reload = 0;
      case (m_phase)
        P_MENU: if (press) begin m_phase = P_WAIT_SERVE; m_wait = SERVE_FRAMES; end
        P_WAIT_SERVE: begin
          if (frame_tick && m_wait > 0) m_wait--;
          else if (m_wait == 0) m_phase = P_RALLY;
          if (frame_tick && m_wait == 0) m_phase = P_RALLY;
        end
        P_RALLY: begin
          if (brick_hit) m_score = (m_score + POINTS > 255) ? 255 : m_score + POINTS;
          if (bricks_clear) m_phase = P_CLEARED;
          else if (ball_lost) begin
            m_lives--;
            if (m_lives == 0) m_phase = P_DEAD;
            else begin m_phase = P_MISSED; m_wait = LOST_FRAMES; end
          end
        end
        P_MISSED: begin
          if (frame_tick && m_wait > 0) m_wait--;
          else if (m_wait == 0) m_wait = -1;
          if (m_wait <= 0) begin m_phase = P_WAIT_SERVE; m_wait = SERVE_FRAMES; end
        end
        P_CLEARED: begin
          if (m_level >= MAX_LEVEL) m_phase = P_CHAMP;
          else begin m_level++; m_reload = 1; m_phase = P_WAIT_SERVE; m_wait = SERVE_FRAMES; end
        end
        default: if (press) begin
          m_phase = P_MENU; m_lives = LIVES; m_score = 0; m_level = 1; m_reload = 1;
        end
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("ball_run", int'(ball_run), int'(m_phase == P_RALLY));
      chk("ball_hold", int'(ball_hold), int'(m_phase != P_RALLY));
      chk("run_hold_excl", int'(ball_run ^ ball_hold), 1);
      chk("brick_reload", int'(brick_reload), int'(m_reload));
      chk("lives", int'(lives), m_lives);
      chk("score", int'(score), m_score);
      chk("level", int'(level), m_level);
      chk("game_over", int'(game_over), int'(m_phase == P_DEAD));
      chk("win", int'(win), int'(m_phase == P_CHAMP));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic tick();
    frame_tick = 1; cyc(1); frame_tick = 0; cyc(1);
  endtask
  task automatic hit();
    brick_hit = 1; cyc(1); brick_hit = 0; cyc(1);
  endtask
  task automatic lose();
    ball_lost = 1; cyc(1); ball_lost = 0; cyc(1);
  endtask
  task automatic press();
    start = 1; cyc(1); start = 0; cyc(1);
  endtask
  task automatic serve();
    press(); tick(); tick();
  endtask
  task automatic clear_lvl();
    bricks_clear = 1; cyc(1); bricks_clear = 0; cyc(1);
  endtask

  initial begin
    cyc(2);
    chk("rst_hold", int'(ball_hold), 1);
    chk("rst_lives", int'(lives), 3);
    chk("rst_level", int'(level), 1);
    reset = 1; cyc(1);
    chk("rst_score", int'(score), 0);

    // serve with two frames, then a rally
    serve();
    chk("serve_run", int'(ball_run), 1);
    chk("serve_hold", int'(ball_hold), 0);
    hit(); hit(); hit();
    chk("score_30", int'(score), 30);

    // three misses
    lose();
    chk("lost1_lives", int'(lives), 2);
    chk("lost1_run", int'(ball_run), 0);
    hit();
    repeat (3) tick();
    chk("lost1_still_held", int'(ball_run), 0);
    tick(); tick();
    chk("reserve_run", int'(ball_run), 1);
    lose();
    chk("lost2_lives", int'(lives), 1);
    repeat (5) tick();
    lose();
    chk("dead_lives", int'(lives), 0);
    chk("dead_flag", int'(game_over), 1);
    hit();
    chk("dead_score", int'(score), 30);

    // new game, then clear + miss coincident with a hit
    press();
    chk("new_lives", int'(lives), 3);
    chk("new_score", int'(score), 0);
    serve();
    bricks_clear = 1; ball_lost = 1; brick_hit = 1; cyc(1);
    bricks_clear = 0; ball_lost = 0; brick_hit = 0; cyc(1);
    chk("clr_reload", int'(brick_reload), 1);
    chk("clr_level", int'(level), 2);
    chk("clr_lives", int'(lives), 3);
    chk("clr_score", int'(score), 10);
    cyc(1);
    chk("clr_reload_done", int'(brick_reload), 0);

    // levels 2..4, win
    tick(); tick(); clear_lvl(); cyc(1);
    tick(); tick(); clear_lvl(); cyc(1);
    tick(); tick(); clear_lvl();
    chk("win_flag", int'(win), 1);
    chk("win_no_reload", int'(brick_reload), 0);
    chk("win_level", int'(level), 4);
    start = 1; cyc(1);
    chk("rew_reload", int'(brick_reload), 1);
    chk("rew_win", int'(win), 0);
    chk("rew_level", int'(level), 1);
    start = 0; cyc(1);

    // score saturation at 8 bits
    serve();
    repeat (25) hit();
    chk("score_250", int'(score), 250);
    hit();
    chk("score_sat", int'(score), 255);
    hit();
    chk("score_sat2", int'(score), 255);

    // reset mid-LOST with start held across release
    lose(); tick();
    reset = 0; start = 1; cyc(1);
    chk("rst_lost_lives", int'(lives), 3);
    chk("rst_lost_score", int'(score), 0);
    reset = 1; cyc(2); repeat (3) tick();
    chk("held_start_no_serve", int'(ball_run), 0);
    start = 0; cyc(1);

    // reset mid-SERVE
    press(); tick();
    reset = 0; cyc(1);
    chk("rst_serve_hold", int'(ball_hold), 1);
    reset = 1; cyc(1); repeat (3) tick();
    chk("rst_serve_idle", int'(ball_run), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/breakout_round_ctrl.md
Name: breakout_round_ctrl

Overview:
- Top-level game sequencer for the Breakout design.
- Owns the lives count, score and level number.
- Decides when the ball is held on the paddle, when it runs, and when it is re-served after a miss.
- Requests brick-wall reloads and raises game-over/win flags for the display logic.

Parameters:
- LIVES, 3, lives at game start (1..7)
- SERVE_FRAMES, 60, frame_ticks the ball is held before launch
- LOST_FRAMES, 90, frame_ticks of pause after a ball is lost
- POINTS, 10, score added per brick_hit
- SCORE_W, 16, score width
- MAX_LEVEL, 4, last level; clearing it wins the game

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 at posedge clk resets the block)
- start  in  1  player start button, level; rising edge detected internally
- frame_tick  in  1  one-cycle pulse per video frame
- brick_hit  in  1  one-cycle pulse, one brick destroyed
- ball_lost  in  1  one-cycle pulse, ball passed the paddle
- bricks_clear  in  1  level, no bricks remain
- ball_run  out  1  ball physics enabled
- ball_hold  out  1  ball parked on paddle centre
- brick_reload  out  1  one-cycle pulse, brick wall restored
- lives  out  3  remaining lives
- score  out  SCORE_W  current score
- level  out  3  current level, 1-based
- game_over  out  1  all lives spent
- win  out  1  MAX_LEVEL cleared

Behaviour:
- All outputs are registered and all state changes occur on the posedge of clk.
- Reset (reset==0):
  - state=IDLE, lives=LIVES, score=0, level=1
  - ball_run=0, ball_hold=1, brick_reload=0, game_over=0, win=0
  - frame counter=0; start edge-detect register cleared to 0
- start_edge = start & ~start_q. Holding start asserted through reset does not produce an edge on the first cycle after reset.
- States: IDLE, SERVE, PLAY, LOST, LVL_CLR, GAME_OVER, WIN.
- IDLE:
  - ball_hold=1.
  - On start_edge: go to SERVE and load counter=SERVE_FRAMES.
- SERVE:
  - ball_hold=1, ball_run=0.
  - Counter decrements on each frame_tick.
  - The frame_tick that takes the counter to 0 moves the state to PLAY, so ball_run=1 from the following cycle.
  - SERVE_FRAMES=0 means PLAY is entered on the next cycle.
- PLAY:
  - ball_run=1, ball_hold=0.
  - brick_hit: score += POINTS, saturating at 2^SCORE_W-1.
  - Priority within one cycle: bricks_clear > ball_lost.
  - bricks_clear: go to LVL_CLR; no life is lost even if ball_lost is high in the same cycle.
  - ball_lost with lives>1: lives-1, go to LOST, counter=LOST_FRAMES.
  - ball_lost with lives==1: lives=0, go to GAME_OVER.
  - A brick_hit coincident with ball_lost or bricks_clear is still scored.
- LOST:
  - ball_run=0, ball_hold=1.
  - Counter decrements on each frame_tick; the tick reaching 0 reloads counter=SERVE_FRAMES and goes to SERVE.
- LVL_CLR (one cycle):
  - If level==MAX_LEVEL: go to WIN; no reload.
  - Otherwise: level+1, brick_reload=1 for exactly one cycle, counter=SERVE_FRAMES, go to SERVE.
- GAME_OVER / WIN:
  - game_over=1 or win=1 respectively; ball_run=0, ball_hold=1.
  - On start_edge: lives=LIVES, score=0, level=1, flags cleared, brick_reload pulse for one cycle, go to IDLE.
- Ignored inputs:
  - brick_hit, ball_lost and bricks_clear are ignored outside PLAY.
  - start_edge is ignored outside IDLE, GAME_OVER and WIN.
- Reset mid-operation in any state returns to the reset values on the next edge; any pending counter value is discarded.
- Exactly one of ball_run/ball_hold is 1 at all times after reset.

Test Plan:
- Reset then start edge, SERVE_FRAMES=2: two frame_ticks, then the next cycle shows ball_run=1, ball_hold=0; lives=3, score=0, level=1.
- In PLAY, 3 brick_hit pulses with POINTS=10 -> score=30. Score preset near max with SCORE_W=8 (250) plus one hit -> score=255 (saturated).
- ball_lost three times (LIVES=3, LOST_FRAMES=3): lives 3->2->1, with 3 frame_ticks of LOST then 2 of SERVE each time; third loss -> lives=0, game_over=1, ball_run=0; brick_hit afterwards leaves score unchanged.
- bricks_clear and ball_lost in the same cycle at level 1 -> lives unchanged, brick_reload high for exactly 1 cycle, level=2, state SERVE.
- Clear levels 1..4 with MAX_LEVEL=4 -> win=1 after the 4th clear, no brick_reload on that clear. A subsequent start edge -> win=0, level=1, score=0, lives=3, one brick_reload pulse, state IDLE.
- Assert reset=0 mid-SERVE and mid-LOST -> next cycle shows the IDLE reset values; start held high across reset release does not launch a serve.
